// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply/divide unit: 32-cycle shift-add multiply and restoring divide
// on operand magnitudes, with a pipeline stall request while busy.
module multdiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             ctrl_stall
);

   typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;

   localparam logic [4:0] LAST_ITER = 5'(WIDTH - 1);

   state_e             state_q;
   logic [4:0]         cnt_q;
   logic               neg_q;
   logic [WIDTH-1:0]   op_q;
   logic [2*WIDTH-1:0] acc_q;

   logic               accepting;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next, prod_signed;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH-1:0]   div_diff, quo_signed;
   logic               div_ge;
   logic [2*WIDTH-1:0] div_next;
   logic               mul_ovf, div_ovf;

   // acc_q holds {partial product, multiplier} for MULT and {remainder, dividend/quotient} for DIV.
   always_comb begin
      accepting   = (state_q == IDLE) || (state_q == DONE);
      mag_a       = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
      mag_b       = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
      mul_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, op_q} : '0);
      mul_next    = {mul_sum, acc_q[WIDTH-1:1]};
      prod_signed = neg_q ? -mul_next : mul_next;
      mul_ovf     = !((&prod_signed[2*WIDTH-1:WIDTH-1]) || !(|prod_signed[2*WIDTH-1:WIDTH-1]));
      div_shift   = acc_q[2*WIDTH-1:WIDTH-1];
      div_ge      = div_shift >= {1'b0, op_q};
      div_diff    = div_shift[WIDTH-1:0] - op_q;
      div_next    = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                           : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      quo_signed  = neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
      // Only a positive quotient can overflow: |q| = 2^31 is representable when negated.
      div_ovf     = !neg_q && div_next[WIDTH-1];
   end

   // NOTE: stall is combinational on the start inputs, so it must be gated by reset explicitly.
   assign ctrl_stall     = reset && ((state_q == MULT) || (state_q == DIV) ||
                                     (accepting && (ctrl_MULT || ctrl_DIV)));
   assign data_resultRDY = (state_q == DONE);

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         neg_q          <= 1'b0;
         op_q           <= '0;
         acc_q          <= '0;
         data_result    <= '0;
         data_exception <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               cnt_q <= '0;
               neg_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
               if (ctrl_MULT) begin
                  op_q    <= mag_a;
                  acc_q   <= {{WIDTH{1'b0}}, mag_b};
                  state_q <= MULT;
               end else if (ctrl_DIV && (data_operandB == '0)) begin
                  op_q           <= '0;
                  acc_q          <= '0;
                  data_result    <= '0;
                  data_exception <= 1'b1;
                  state_q        <= DONE;
               end else if (ctrl_DIV) begin
                  op_q    <= mag_b;
                  acc_q   <= {{WIDTH{1'b0}}, mag_a};
                  state_q <= DIV;
               end else begin
                  state_q <= IDLE;
               end
            end
            MULT: begin
               acc_q <= mul_next;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == LAST_ITER) begin
                  data_result    <= prod_signed[WIDTH-1:0];
                  data_exception <= mul_ovf;
                  state_q        <= DONE;
               end
            end
            DIV: begin
               acc_q <= div_next;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == LAST_ITER) begin
                  data_result    <= quo_signed;
                  data_exception <= div_ovf;
                  state_q        <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: cycle-level reference model compared every
// cycle, plus directed operations with hand-computed results, latency and stall counts.
module tb_multdiv_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        ctrl_stall;

   int errors = 0;
   int checks = 0;

   multdiv_sequencer #(.WIDTH(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .ctrl_stall     (ctrl_stall)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: returns {exception, result}.
   function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      longint p;
      longint lo;
      p  = longint'($signed(a)) * longint'($signed(b));
      lo = longint'($signed(p[31:0]));
      return {p != lo, p[31:0]};
   endfunction

   function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      longint q;
      if (b == 32'd0) return {1'b1, 32'd0};
      q = longint'($signed(a)) / longint'($signed(b));
      return {q > 64'sd2147483647, q[31:0]};
   endfunction

   // Cycle model: busy_cnt = edges left until the result appears (0 = able to accept).
   int          busy_cnt;
   logic        rdy_exp;
   logic [31:0] res_exp;
   logic        exc_exp;
   logic [32:0] pend;
   logic [32:0] start_ref;

   assign start_ref = ctrl_MULT ? ref_mul(data_operandA, data_operandB)
                                : ref_div(data_operandA, data_operandB);

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy_cnt <= 0;
         rdy_exp  <= 1'b0;
         res_exp  <= '0;
         exc_exp  <= 1'b0;
         pend     <= '0;
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
         if (busy_cnt == 1) begin
            rdy_exp <= 1'b1;
            res_exp <= pend[31:0];
            exc_exp <= pend[32];
         end else begin
            rdy_exp <= 1'b0;
         end
      end else if (ctrl_MULT || ctrl_DIV) begin
         if (!ctrl_MULT && data_operandB == 32'd0) begin
            rdy_exp <= 1'b1;
            res_exp <= 32'd0;
            exc_exp <= 1'b1;
         end else begin
            busy_cnt <= 32;
            pend     <= start_ref;
            rdy_exp  <= 1'b0;
         end
      end else begin
         rdy_exp <= 1'b0;
      end
   end

   always @(negedge clock) begin
      check("rdy", 64'(data_resultRDY), 64'(rdy_exp));
      check("stall", 64'(ctrl_stall),
            64'(reset && (busy_cnt > 0 || ctrl_MULT || ctrl_DIV)));
      check("result", 64'(data_result), 64'(res_exp));
      check("exception", 64'(data_exception), 64'(exc_exp));
   end

   // One operation with literal expectations; glitch_at >= 0 pulses ctrl_DIV (with B=0) mid-run.
   task automatic run_op(input string name, input bit m, input bit d,
                         input logic [31:0] a, input logic [31:0] b, input int glitch_at,
                         input logic [31:0] exp_res, input bit exp_exc, input int exp_lat);
      int n;
      int stall_cnt;
      bit seen;
      logic [31:0] got_res;
      logic        got_exc;
      n = 0; seen = 0; got_res = '0; got_exc = 1'b0;
      @(posedge clock); #1;
      ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
      @(negedge clock);
      stall_cnt = int'(ctrl_stall);
      @(posedge clock); #1;
      ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
      data_operandA = $urandom; data_operandB = $urandom;
      while (n < 40 && !seen) begin
         @(negedge clock);
         n++;
         if (ctrl_stall) stall_cnt++;
         if (data_resultRDY) begin
            seen = 1;
            got_res = data_result;
            got_exc = data_exception;
         end else begin
            @(posedge clock); #1;
            ctrl_DIV = (n == glitch_at);
            if (n == glitch_at) data_operandB = 32'd0;
         end
      end
      check({name, " done"}, 64'(seen), 64'd1);
      check({name, " latency"}, 64'(n), 64'(exp_lat + 1));
      check({name, " value"}, 64'(got_res), 64'(exp_res));
      check({name, " exc"}, 64'(got_exc), 64'(exp_exc));
      check({name, " stall cycles"}, 64'(stall_cnt), 64'(exp_lat + 1));
   endtask

   initial begin
      ctrl_MULT = 1'b1;
      #12;
      check("reset result", 64'(data_result), 64'd0);
      check("reset rdy", 64'(data_resultRDY), 64'd0);
      check("reset stall", 64'(ctrl_stall), 64'd0);
      check("reset exc", 64'(data_exception), 64'd0);
      ctrl_MULT = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (2) @(posedge clock);

      run_op("mul 6*-7", 1, 0, 32'd6, 32'hFFFF_FFF9, -1, 32'hFFFF_FFD6, 0, 32);
      run_op("mul ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, -1, 32'h0, 1, 32);
      run_op("mul min*1", 1, 0, 32'h8000_0000, 32'd1, -1, 32'h8000_0000, 0, 32);
      run_op("div -100/7", 0, 1, 32'hFFFF_FF9C, 32'd7, -1, 32'hFFFF_FFF2, 0, 32);
      run_op("div min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 32'h8000_0000, 1, 32);
      run_op("div 5/0", 0, 1, 32'd5, 32'd0, -1, 32'h0, 1, 0);
      run_op("both 3*4", 1, 1, 32'd3, 32'd4, -1, 32'd12, 0, 32);
      run_op("mul div-glitch", 1, 0, 32'h1234, 32'h10, 10, 32'h12340, 0, 32);

      // Abort a multiply mid-run with reset.
      @(posedge clock); #1;
      ctrl_MULT = 1'b1; data_operandA = 32'd7; data_operandB = 32'd7;
      @(posedge clock); #1;
      ctrl_MULT = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      reset = 1'b0;
      ctrl_MULT = 1'b1;
      #1;
      check("abort result", 64'(data_result), 64'd0);
      check("abort exc", 64'(data_exception), 64'd0);
      check("abort rdy", 64'(data_resultRDY), 64'd0);
      check("abort stall", 64'(ctrl_stall), 64'd0);
      repeat (3) @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      reset = 1'b1;
      repeat (40) @(posedge clock);
      run_op("mul 9*9 after reset", 1, 0, 32'd9, 32'd9, -1, 32'd81, 0, 32);

      // Random traffic: starts at any time, including while busy and in DONE.
      for (int i = 0; i < 4000; i++) begin
         @(posedge clock); #1;
         ctrl_MULT = ($urandom_range(0, 11) == 0);
         ctrl_DIV  = ($urandom_range(0, 11) == 0);
         for (int k = 0; k < 2; k++) begin
            logic [31:0] v;
            case ($urandom_range(0, 7))
               0: v = 32'd0;
               1: v = 32'h8000_0000;
               2: v = 32'hFFFF_FFFF;
               3: v = 32'd1;
               4: v = $urandom_range(0, 255);
               default: v = $urandom;
            endcase
            if (k == 0) data_operandA = v; else data_operandB = v;
         end
      end
      @(posedge clock); #1;
      ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
      repeat (40) @(posedge clock);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multdiv_sequencer.md
MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only WIDTH=32 is supported and verified.
REQ-002 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port ctrl_MULT  input  1  start signed multiply, sampled on a rising edge.
REQ-005 SHALL have port ctrl_DIV  input  1  start signed divide, sampled on a rising edge.
REQ-006 SHALL have port data_operandA  input  WIDTH  multiplicand / dividend, captured at start.
REQ-007 SHALL have port data_operandB  input  WIDTH  multiplier / divisor, captured at start.
REQ-008 SHALL have port data_result  output  WIDTH  product low word or quotient, registered.
REQ-009 SHALL have port data_exception  output  1  overflow or divide-by-zero flag, registered.
REQ-010 SHALL have port data_resultRDY  output  1  one-cycle completion pulse.
REQ-011 SHALL have port ctrl_stall  output  1  pipeline freeze request to the decode/execute stage.

Function
REQ-012 SHALL implement FSM states IDLE, MULT, DIV, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-013 SHALL accept a start only in IDLE or DONE; ctrl_MULT/ctrl_DIV in MULT or DIV are ignored, with no restart and no operand recapture.
REQ-014 SHALL give ctrl_MULT priority when ctrl_MULT and ctrl_DIV are both high at an accepting edge; the divide is dropped.
REQ-015 SHALL, on an accepted start at edge k, latch both operands and a 5-bit iteration counter = 0, then enter MULT or DIV.
REQ-016 SHALL perform one iteration per edge k+1..k+WIDTH, with the counter incrementing; edge k+WIDTH SHALL enter DONE, so data_resultRDY is high only in the cycle between edges k+WIDTH and k+WIDTH+1.
REQ-017 SHALL multiply by unsigned shift-add on operand magnitudes into a 2*WIDTH accumulator, applying the sign (A[31] XOR B[31]) on entry to DONE.
REQ-018 SHALL set data_result to the low WIDTH bits of the signed 2*WIDTH product.
REQ-019 SHALL raise multiply exception when the signed product does not fit in WIDTH bits; -2^31 * 1 SHALL NOT raise it.
REQ-020 SHALL divide by restoring division on magnitudes, quotient truncated toward zero, sign = A[31] XOR B[31]; the remainder is discarded.
REQ-021 SHALL, when the divisor is 0 at start, go directly to DONE at edge k with result 0 and exception 1 (data_resultRDY one cycle after the start edge).
REQ-022 SHALL, for 0x80000000 / 0xFFFFFFFF, give result 0x80000000 and exception 1 after full WIDTH-cycle latency.
REQ-023 SHALL update data_result and data_exception only on entry to DONE, holding them until the next DONE entry.
REQ-024 SHALL drive ctrl_stall = (state is MULT or DIV) OR (state is IDLE/DONE AND (ctrl_MULT OR ctrl_DIV)); it is combinational and low in DONE without a new start.
REQ-025 SHALL drive data_resultRDY from the state register only (high iff state is DONE).
REQ-026 SHALL produce no X on any output after reset, for any operand values.

Reset
REQ-027 SHALL, while reset=0, force state IDLE, counter 0, accumulators 0, data_result 0, data_exception 0, data_resultRDY 0, ctrl_stall 0, independent of clock.
REQ-028 SHALL, on reset assertion mid-operation, abort the operation with no data_resultRDY pulse; the first start after release behaves as from power-up.

Verification
REQ-029 SHALL verify: MULT with A=6, B=0xFFFFFFF9 -> result 0xFFFFFFD6, exception 0, RDY exactly 32 cycles after the start edge, ctrl_stall high from the start cycle for 33 cycles.
REQ-030 SHALL verify: MULT with 0x00010000 * 0x00010000 -> result 0x00000000, exception 1; 0x80000000 * 1 -> 0x80000000, exception 0.
REQ-031 SHALL verify: DIV with 0xFFFFFF9C / 7 -> 0xFFFFFFF2, exception 0; 0x80000000 / 0xFFFFFFFF -> 0x80000000, exception 1.
REQ-032 SHALL verify: DIV with 5 / 0 -> result 0, exception 1, RDY in the cycle after the start edge, ctrl_stall high only in the start cycle.
REQ-033 SHALL verify: ctrl_DIV pulse at iteration 10 of a MULT is ignored; simultaneous ctrl_MULT+ctrl_DIV (A=3, B=4) yields the product 12.
REQ-034 SHALL verify: reset=0 at iteration 10 -> all outputs 0 immediately, no RDY pulse; after release, a new 9*9 start yields 81 at 32-cycle latency.
